ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-port arbiter that shares the single-port data RAM between requester 0 (CPU load/store path) and requester 1 (loader/debug master).
- Sits directly in front of the RAM.
- Drives the RAM's one-hot write_enable, addr and data_in.
- Returns registered-latency read data to whichever requester issued the read.
- Round-robin grant with a bounded burst, so neither side starves.

Parameters:
- MAX_BURST, 4: max consecutive grants to one requester while the other has req_valid high (range 1..7).
- RAM_LATENCY, 1: cycles from read acceptance to data on mem_data_out. Fixed at 1; other values are unsupported.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- r0_valid  in  1  requester 0 transaction present
- r0_ready  out  1  requester 0 transaction accepted this cycle
- r0_we  in  3  one-hot: [0] word, [1] half, [2] byte store; 0 = read
- r0_addr  in  32  byte address
- r0_wdata  in  32  store data, low-aligned
- r0_rvalid  out  1  read data valid for requester 0
- r0_rdata  out  32  read data
- r1_valid, r1_ready, r1_we, r1_addr, r1_wdata, r1_rvalid, r1_rdata: same as r0_* for requester 1
- mem_write_enable  out  3  to RAM write_enable
- mem_addr  out  32  to RAM addr
- mem_data_in  out  32  to RAM data_in
- mem_data_out  in  32  from RAM data_out (registered in RAM)

Behaviour:
- Reset: one clock, synchronous and active-high. While reset is high:
  - r0_ready, r1_ready, r0_rvalid, r1_rvalid = 0
  - mem_write_enable = 0, mem_addr = 0, mem_data_in = 0
  - last_grant = 1, so requester 0 wins first; burst_cnt = 0; rsp_pending = 0
- Handshake: a transaction transfers when rN_valid && rN_ready. Requesters hold valid, we, addr and wdata stable until ready. Ready may depend combinationally on valid.
- Grant, combinational from registered state:
  - Only one valid: grant it, unless the burst limit blocks it (it never does when alone).
  - Both valid: grant the requester != last_grant; if burst_cnt < MAX_BURST, the last_grant requester may keep the grant.
  - Restated: the same requester can win at most MAX_BURST consecutive contested cycles; then the other requester must win.
  - Neither valid: no grant; mem_write_enable = 0, mem_addr = 0.
- Granted cycle: mem_* = granted requester's we, addr and wdata; its ready = 1; the other ready = 0. Exactly one transfer per cycle maximum.
- State update on a transfer:
  - Same requester as last_grant: burst_cnt saturates-increments.
  - Otherwise: last_grant <= granted, burst_cnt <= 1.
  - Idle cycle: burst_cnt <= 0.
- Writes: complete in the acceptance cycle with no response. we is passed through unchanged, including any multi-bit value, where the RAM's own priority applies.
- Reads (we == 0), accepted in cycle N:
  - rsp_pending <= 1 and rsp_owner <= granted.
  - In cycle N+1, rOwner_rvalid = 1 and rOwner_rdata = mem_data_out.
  - The other rdata holds its last value. rvalid is a single-cycle pulse.
- Back-to-back reads, from either requester, are accepted every cycle, giving one response per cycle in order. No backpressure on responses; requesters must always sink rvalid.
- Read in N then write in N+1: legal. The read response in N+1 reflects memory contents before the write.
- Reset asserted in cycle N+1 after a read accepted in N: the response is dropped (rvalid stays 0).
- GPIO byte store to 0xa0: forwarded like any byte store. No special handling.
- Reading rN_rdata without rvalid is undefined; the bench must not check it.

Test Plan:
- Reset then idle, both valid = 0 for 5 cycles -> all ready/rvalid 0, mem_write_enable = 0, mem_addr = 0.
- r0 word write 0xDEADBEEF @0x10 (we = 3'b001), then r0 read @0x10 -> r0_ready same cycle; r0_rvalid exactly 1 cycle after read accept with r0_rdata = 0xDEADBEEF; r1_rvalid stays 0.
- Both valid continuously for 12 reads (r0 @0x100+, r1 @0x200+), MAX_BURST = 4 -> first grant to r0; grants never exceed 4 consecutive to one side; each rvalid lands at the correct owner one cycle after its accept.
- Only r1 valid for 10 cycles -> r1 granted all 10 (burst limit inactive when uncontested); burst_cnt saturates at MAX_BURST, with no lockout.
- r1 byte store 0x5A @0x13 (we = 3'b100), then r0 word read @0x10 -> r0_rdata[31:24] = 0x5A, other bytes unchanged.
- r0 read accepted, reset asserted next cycle -> r0_rvalid stays 0; after reset release, first contested grant goes to r0.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port data RAM between two requesters.
//
// Requester 0 is the CPU load/store path, requester 1 is the loader/debug master.
// Grants are round-robin with a bounded burst: a requester may hold the RAM for at
// most MAX_BURST consecutive contested cycles before the other side must win.
// Writes complete in the acceptance cycle. Reads return one cycle later on the
// owner's rvalid/rdata. The RAM registers its read data.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   rN_valid / rN_ready        request handshake (ready is combinational on valid)
//   rN_we                      one-hot store size: [0] word, [1] half, [2] byte; 0 = read
//   rN_addr, rN_wdata          byte address and low-aligned store data
//   rN_rvalid, rN_rdata        single-cycle read response pulse and data
//   mem_write_enable, mem_addr, mem_data_in   to the RAM
//   mem_data_out               registered read data from the RAM
module ram_arbiter #(
    parameter int unsigned MAX_BURST   = 4,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [2:0]  r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_rvalid,
    output logic [31:0] r0_rdata,

    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [2:0]  r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_rvalid,
    output logic [31:0] r1_rdata,

    output logic [2:0]  mem_write_enable,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    // The response path assumes the RAM returns data exactly one cycle after the address.
    if (RAM_LATENCY != 1) begin : g_unsupported_latency
        $error("ram_arbiter: only RAM_LATENCY == 1 is supported");
    end

    localparam logic [2:0] LP_MAX_BURST = 3'(MAX_BURST);

    // Registered arbitration and response state
    logic        r_last_grant;
    logic [2:0]  r_burst_cnt;
    logic        r_rsp_pending;
    logic        r_rsp_owner;
    logic [31:0] r_r0_rdata;
    logic [31:0] r_r1_rdata;

    // Combinational grant
    logic        w_grant_valid;
    logic        w_grant;
    logic [2:0]  w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_xfer;
    logic        w_is_read;

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = 1'b0;
        unique case ({r1_valid, r0_valid})
            2'b01: begin
                w_grant_valid = 1'b1;
                w_grant       = 1'b0;
            end
            2'b10: begin
                w_grant_valid = 1'b1;
                w_grant       = 1'b1;
            end
            2'b11: begin
                w_grant_valid = 1'b1;
                // burst_cnt == 0 means no burst is running (reset or idle gap), so the
                // non-last requester wins; this makes requester 0 first after reset.
                if ((r_burst_cnt != 3'd0) && (r_burst_cnt < LP_MAX_BURST)) begin
                    w_grant = r_last_grant;
                end else begin
                    w_grant = ~r_last_grant;
                end
            end
            default: begin
                w_grant_valid = 1'b0;
                w_grant       = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_sel_we    = w_grant ? r1_we    : r0_we;
        w_sel_addr  = w_grant ? r1_addr  : r0_addr;
        w_sel_wdata = w_grant ? r1_wdata : r0_wdata;
        w_xfer      = w_grant_valid && !reset;
        w_is_read   = (w_sel_we == 3'b000);
    end

    always_comb begin
        r0_ready         = w_xfer && !w_grant;
        r1_ready         = w_xfer &&  w_grant;
        mem_write_enable = w_xfer ? w_sel_we    : 3'b000;
        mem_addr         = w_xfer ? w_sel_addr  : 32'h0;
        mem_data_in      = w_xfer ? w_sel_wdata : 32'h0;
    end

    // Response: a pending read that meets an asserted reset is dropped
    always_comb begin
        r0_rvalid = r_rsp_pending && !r_rsp_owner && !reset;
        r1_rvalid = r_rsp_pending &&  r_rsp_owner && !reset;
        r0_rdata  = r0_rvalid ? mem_data_out : r_r0_rdata;
        r1_rdata  = r1_rvalid ? mem_data_out : r_r1_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant  <= 1'b1;
            r_burst_cnt   <= 3'd0;
            r_rsp_pending <= 1'b0;
            r_rsp_owner   <= 1'b0;
        end else begin
            if (w_xfer) begin
                if (w_grant == r_last_grant) begin
                    if (r_burst_cnt < LP_MAX_BURST) begin
                        r_burst_cnt <= r_burst_cnt + 3'd1;
                    end
                end else begin
                    r_last_grant <= w_grant;
                    r_burst_cnt  <= 3'd1;
                end
            end else begin
                r_burst_cnt <= 3'd0;
            end
            r_rsp_pending <= w_xfer && w_is_read;
            r_rsp_owner   <= w_grant;
        end
    end

    // Non-owner rdata holds its last delivered value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_r0_rdata <= 32'h0;
            r_r1_rdata <= 32'h0;
        end else begin
            if (r0_rvalid) begin
                r_r0_rdata <= mem_data_out;
            end
            if (r1_rvalid) begin
                r_r1_rdata <= mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: RAM model behind the arbiter, two-requester directed
// stimulus, and a scoreboard queue checked by an independent response monitor.
module tb_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        r0_valid, r0_ready, r0_rvalid;
    logic [2:0]  r0_we;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_valid, r1_ready, r1_rvalid;
    logic [2:0]  r1_we;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic [2:0]  mem_write_enable;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;

    int n_checks = 0;
    int n_errors = 0;

    ram_arbiter #(
        .MAX_BURST  (4),
        .RAM_LATENCY(1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .r0_valid        (r0_valid),
        .r0_ready        (r0_ready),
        .r0_we           (r0_we),
        .r0_addr         (r0_addr),
        .r0_wdata        (r0_wdata),
        .r0_rvalid       (r0_rvalid),
        .r0_rdata        (r0_rdata),
        .r1_valid        (r1_valid),
        .r1_ready        (r1_ready),
        .r1_we           (r1_we),
        .r1_addr         (r1_addr),
        .r1_wdata        (r1_wdata),
        .r1_rvalid       (r1_rvalid),
        .r1_rdata        (r1_rdata),
        .mem_write_enable(mem_write_enable),
        .mem_addr        (mem_addr),
        .mem_data_in     (mem_data_in),
        .mem_data_out    (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read (old data on read-during-write), word > half > byte priority
    logic [31:0] ram [0:1023];

    function automatic logic [31:0] init_word(input logic [31:0] addr);
        return {16'hC0DE, 6'd0, addr[11:2]};
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = init_word(32'(i) << 2);
        mem_data_out = 32'h0;
    end

    always @(posedge clk) begin
        logic [9:0] wi;
        wi = mem_addr[11:2];
        mem_data_out <= ram[wi];
        if (mem_write_enable[0]) begin
            ram[wi] <= mem_data_in;
        end else if (mem_write_enable[1]) begin
            if (mem_addr[1]) ram[wi][31:16] <= mem_data_in[15:0];
            else             ram[wi][15:0]  <= mem_data_in[15:0];
        end else if (mem_write_enable[2]) begin
            case (mem_addr[1:0])
                2'd0: ram[wi][7:0]   <= mem_data_in[7:0];
                2'd1: ram[wi][15:8]  <= mem_data_in[7:0];
                2'd2: ram[wi][23:16] <= mem_data_in[7:0];
                default: ram[wi][31:24] <= mem_data_in[7:0];
            endcase
        end
    end

    typedef struct {
        logic [2:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } txn_t;

    typedef struct {
        logic        owner;
        logic [31:0] data;
    } rsp_t;

    txn_t q0[$];
    txn_t q1[$];
    rsp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Response monitor: pops the scoreboard on every rvalid
    always @(negedge clk) begin
        if (r0_rvalid || r1_rvalid) begin
            rsp_t e;
            check("rvalid_one_hot", 32'(r0_rvalid && r1_rvalid), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_rvalid", {31'd0, r1_rvalid}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("rsp_owner", {31'd0, r1_rvalid}, {31'd0, e.owner});
                check("rsp_data", r1_rvalid ? r1_rdata : r0_rdata, e.data);
            end
        end
    end

    function automatic txn_t rd(input logic [31:0] a, input logic [31:0] e);
        txn_t t;
        t.we = 3'b000; t.addr = a; t.wdata = 32'h0; t.exp = e;
        return t;
    endfunction

    function automatic txn_t wr(input logic [2:0] we, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.exp = 32'h0;
        return t;
    endfunction

    // Drives q0/q1 to completion. order[k] is the expected owner of the k-th accept.
    // Called and returns just after a rising edge.
    task automatic run(input int order_len, input logic [15:0] order, input int max_cycles);
        int i0 = 0;
        int i1 = 0;
        int n  = 0;
        int cyc = 0;
        forever begin
            r0_valid = (i0 < q0.size());
            r1_valid = (i1 < q1.size());
            if (r0_valid) begin r0_we = q0[i0].we; r0_addr = q0[i0].addr; r0_wdata = q0[i0].wdata; end
            if (r1_valid) begin r1_we = q1[i1].we; r1_addr = q1[i1].addr; r1_wdata = q1[i1].wdata; end
            if (!r0_valid && !r1_valid) break;
            @(negedge clk);
            cyc++;
            if (cyc > max_cycles) begin
                check("run_cycle_budget", 32'(cyc), 32'(max_cycles));
                break;
            end
            if (r0_ready && r1_ready) check("ready_one_hot", 32'd1, 32'd0);
            if (r0_valid && r0_ready) begin
                check("mem_we_r0", {29'd0, mem_write_enable}, {29'd0, q0[i0].we});
                check("mem_addr_r0", mem_addr, q0[i0].addr);
                if (q0[i0].we != 3'b000) check("mem_wdata_r0", mem_data_in, q0[i0].wdata);
                else sb.push_back('{owner: 1'b0, data: q0[i0].exp});
                if (n < order_len) check("grant_owner", 32'd0, {31'd0, order[n]});
                n++;
                i0++;
            end else if (r1_valid && r1_ready) begin
                check("mem_we_r1", {29'd0, mem_write_enable}, {29'd0, q1[i1].we});
                check("mem_addr_r1", mem_addr, q1[i1].addr);
                if (q1[i1].we != 3'b000) check("mem_wdata_r1", mem_data_in, q1[i1].wdata);
                else sb.push_back('{owner: 1'b1, data: q1[i1].exp});
                if (n < order_len) check("grant_owner", 32'd1, {31'd0, order[n]});
                n++;
                i1++;
            end
            @(posedge clk);
            #1;
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        r0_we    = 3'b001;
        r1_we    = 3'b001;
        r0_addr  = 32'h44;
        r1_addr  = 32'h48;
        @(negedge clk);
        check("rst_r0_ready", {31'd0, r0_ready}, 32'd0);
        check("rst_r1_ready", {31'd0, r1_ready}, 32'd0);
        check("rst_mem_we", {29'd0, mem_write_enable}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_din", mem_data_in, 32'd0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        r0_valid = 1'b0; r0_we = 3'b000; r0_addr = 32'h0; r0_wdata = 32'h0;
        r1_valid = 1'b0; r1_we = 3'b000; r1_addr = 32'h0; r1_wdata = 32'h0;
        do_reset();

        // Idle after reset: nothing granted or returned
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_ready", {30'd0, r1_ready, r0_ready}, 32'd0);
            check("idle_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
            check("idle_mem_we", {29'd0, mem_write_enable}, 32'd0);
            check("idle_mem_addr", mem_addr, 32'd0);
        end
        @(posedge clk);
        #1;

        // r0 word write then read back
        q0.push_back(wr(3'b001, 32'h10, 32'hDEADBEEF));
        q0.push_back(rd(32'h10, 32'hDEADBEEF));
        run(2, 16'h0000, 4);
        idle(3);

        // Contested reads after reset: r0 x4, r1 x4, r0 x2, then r1 alone
        do_reset();
        for (int i = 0; i < 6; i++) begin
            q0.push_back(rd(32'h100 + 32'(4 * i), 32'hC0DE0040 + 32'(i)));
            q1.push_back(rd(32'h200 + 32'(4 * i), 32'hC0DE0080 + 32'(i)));
        end
        run(12, 16'h0CF0, 14);
        idle(3);

        // r1 alone for 10 back-to-back reads: one accept every cycle
        for (int i = 0; i < 10; i++) q1.push_back(rd(32'h300 + 32'(4 * i), 32'hC0DE00C0 + 32'(i)));
        run(10, 16'h03FF, 10);
        // Saturated burst on r1, no idle gap: contested grant must move to r0
        q0.push_back(rd(32'h40, 32'hC0DE0010));
        q1.push_back(rd(32'h44, 32'hC0DE0011));
        run(2, 16'h0002, 4);
        idle(3);

        // r1 byte store into the top lane of the word at 0x10, then r0 word read
        q1.push_back(wr(3'b100, 32'h13, 32'h0000005A));
        run(1, 16'h0001, 3);
        q0.push_back(rd(32'h10, 32'h5AADBEEF));
        run(1, 16'h0000, 3);
        // Read, write, read to the same word: first read sees pre-write data
        q0.push_back(rd(32'h20, 32'hC0DE0008));
        q0.push_back(wr(3'b001, 32'h20, 32'h11111111));
        q0.push_back(rd(32'h20, 32'h11111111));
        run(3, 16'h0000, 4);
        // Half store to the upper half of 0x20
        q1.push_back(wr(3'b010, 32'h22, 32'h0000BEEF));
        q1.push_back(rd(32'h20, 32'hBEEF1111));
        run(2, 16'h0003, 4);
        idle(3);

        // Read accepted, reset in the following cycle: response dropped
        q0.push_back(rd(32'h10, 32'h5AADBEEF));
        run(1, 16'h0000, 3);
        reset = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        check("dropped_r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
        check("dropped_r1_rvalid", {31'd0, r1_rvalid}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q0.push_back(rd(32'h50, 32'hC0DE0014));
        q1.push_back(rd(32'h54, 32'hC0DE0015));
        run(2, 16'h0002, 4);
        idle(3);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
